// File: rtl/not_gate.sv
// Bitwise inverter with an optional clocked monitor path: a registered complement,
// per-bit edge pulses and a saturating count of edges at which the input changed.
module not_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] O_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [CNT_W-1:0] toggle_cnt
);

  // Holds at all ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] i_d_p1;
  logic             changed_p0;

  // Primary output: no clock or reset involvement, so it works with the side path unconnected.
  assign O = ~I;

  assign changed_p0 = (I != i_d_p1);

  // Stage p0 -> p1: sample I, derive pulses relative to the previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_d_p1     <= '0;
      O_q        <= '1;
      rise       <= '0;
      fall       <= '0;
      toggle_cnt <= '0;
    end else begin
      i_d_p1 <= I;
      O_q    <= ~I;
      rise   <= I & ~i_d_p1;
      fall   <= ~I & i_d_p1;
      if (changed_p0)
        toggle_cnt <= sat_inc(toggle_cnt);
    end
  end

endmodule

// File: tb/tb_not_gate.sv
// Directed bench for not_gate: a 4-bit/16-bit-counter instance and a 1-bit/3-bit-counter
// instance, checked every cycle against a behavioural model plus literal expectations.
module tb_not_gate;

  logic clk = 1'b0;
  logic clk_en = 1'b0;

  logic       a_rst = 1'b0;
  logic [3:0] a_i = 4'b0000;
  logic [3:0] a_o, a_oq, a_rise, a_fall;
  logic [15:0] a_cnt;

  logic       b_rst = 1'b0;
  logic       b_i = 1'b0;
  logic       b_o, b_oq, b_rise, b_fall;
  logic [2:0] b_cnt;

  int checks = 0;
  int errors = 0;

  not_gate #(.WIDTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .I(a_i), .O(a_o), .O_q(a_oq),
    .rise(a_rise), .fall(a_fall), .toggle_cnt(a_cnt)
  );

  not_gate #(.WIDTH(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst(b_rst), .I(b_i), .O(b_o), .O_q(b_oq),
    .rise(b_rise), .fall(b_fall), .toggle_cnt(b_cnt)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: previous sample, integer transition count clipped at the maximum.
  bit         a_valid = 0, b_valid = 0;
  logic [3:0] a_prev, a_eoq, a_er, a_ef;
  int         a_ec;
  logic       b_prev, b_eoq, b_er, b_ef;
  int         b_ec;

  always @(posedge clk) begin
    if (a_rst) begin
      a_valid = 1; a_prev = 4'h0; a_eoq = 4'hF; a_er = 4'h0; a_ef = 4'h0; a_ec = 0;
    end else if (a_valid) begin
      a_eoq = 4'hF ^ a_i;
      a_er = 4'h0; a_ef = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (a_i[k] == 1'b1 && a_prev[k] == 1'b0) a_er[k] = 1'b1;
        if (a_i[k] == 1'b0 && a_prev[k] == 1'b1) a_ef[k] = 1'b1;
      end
      if (a_i != a_prev) a_ec = (a_ec + 1 > 65535) ? 65535 : a_ec + 1;
      a_prev = a_i;
    end
    if (b_rst) begin
      b_valid = 1; b_prev = 0; b_eoq = 1; b_er = 0; b_ef = 0; b_ec = 0;
    end else if (b_valid) begin
      b_eoq = (b_i == 1'b0);
      b_er  = (b_i == 1'b1) && (b_prev == 1'b0);
      b_ef  = (b_i == 1'b0) && (b_prev == 1'b1);
      if (b_i != b_prev) b_ec = (b_ec + 1 > 7) ? 7 : b_ec + 1;
      b_prev = b_i;
    end
  end

  // Compare process: inputs only change 2 time units after a rising edge, so the falling edge is quiet.
  always @(negedge clk) begin
    check("a_O", 32'(a_o), 32'(4'hF ^ a_i));
    check("b_O", 32'(b_o), 32'(!b_i));
    if (a_valid) begin
      check("a_O_q", 32'(a_oq), 32'(a_eoq));
      check("a_rise", 32'(a_rise), 32'(a_er));
      check("a_fall", 32'(a_fall), 32'(a_ef));
      check("a_cnt", 32'(a_cnt), 32'(a_ec));
    end
    if (b_valid) begin
      check("b_O_q", 32'(b_oq), 32'(b_eoq));
      check("b_rise", 32'(b_rise), 32'(b_er));
      check("b_fall", 32'(b_fall), 32'(b_ef));
      check("b_cnt", 32'(b_cnt), 32'(b_ec));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Combinational path with the clock stopped.
    a_i = 4'b1010; #1;
    check("comb_a_1010", 32'(a_o), 32'h5);
    a_i = 4'b0001; #1;
    check("comb_a_0001", 32'(a_o), 32'hE);
    b_i = 1'b1; #1;
    check("comb_b_1", 32'(b_o), 32'h0);
    b_i = 1'b0; #1;
    check("comb_b_0", 32'(b_o), 32'h1);

    clk_en = 1'b1;
    @(posedge clk); #2;

    // Reset with I=1.
    a_rst = 1'b1; a_i = 4'b0011;
    b_rst = 1'b1; b_i = 1'b1;
    tick();
    check("rst_b_O_q", 32'(b_oq), 32'h1);
    check("rst_b_rise", 32'(b_rise), 32'h0);
    check("rst_b_fall", 32'(b_fall), 32'h0);
    check("rst_b_cnt", 32'(b_cnt), 32'h0);
    check("rst_b_O", 32'(b_o), 32'h0);
    check("rst_a_O_q", 32'(a_oq), 32'hF);
    a_rst = 1'b0; b_rst = 1'b0;

    // First edge after reset: I=1 is a rise against the cleared previous sample.
    tick();
    check("reg1_b_O_q", 32'(b_oq), 32'h0);
    check("reg1_b_rise", 32'(b_rise), 32'h1);
    check("reg1_b_cnt", 32'(b_cnt), 32'h1);
    check("reg1_a_rise", 32'(a_rise), 32'h3);
    check("reg1_a_cnt", 32'(a_cnt), 32'h1);
    b_i = 1'b0;
    a_i = 4'b0101;
    tick();
    check("reg2_b_O_q", 32'(b_oq), 32'h1);
    check("reg2_b_fall", 32'(b_fall), 32'h1);
    check("reg2_b_rise", 32'(b_rise), 32'h0);
    check("reg2_b_cnt", 32'(b_cnt), 32'h2);
    check("reg2_a_rise", 32'(a_rise), 32'h4);
    check("reg2_a_fall", 32'(a_fall), 32'h2);
    check("reg2_a_cnt", 32'(a_cnt), 32'h2);

    // Hold for 5 edges: no pulses, count frozen.
    for (int n = 0; n < 5; n++) tick();
    check("hold_a_rise", 32'(a_rise), 32'h0);
    check("hold_a_fall", 32'(a_fall), 32'h0);
    check("hold_a_cnt", 32'(a_cnt), 32'h2);
    check("hold_b_cnt", 32'(b_cnt), 32'h2);

    // Glitch between edges: O follows, side path does not see it.
    a_i = 4'b1111; #1;
    check("glitch_a_O", 32'(a_o), 32'h0);
    a_i = 4'b0101;
    tick();
    check("glitch_a_cnt", 32'(a_cnt), 32'h2);
    check("glitch_a_rise", 32'(a_rise), 32'h0);

    // Multi-bit change counts once.
    a_i = 4'b1010;
    tick();
    check("multi_a_cnt", 32'(a_cnt), 32'h3);
    check("multi_a_rise", 32'(a_rise), 32'hA);
    check("multi_a_fall", 32'(a_fall), 32'h5);

    // Saturation on the 3-bit counter: 10 toggles stop at 7.
    for (int n = 0; n < 10; n++) begin
      b_i = ~b_i;
      a_i = a_i ^ 4'(n + 1);
      tick();
    end
    check("sat_b_cnt", 32'(b_cnt), 32'h7);
    tick();
    check("sat_hold_b_cnt", 32'(b_cnt), 32'h7);

    // Reset mid-run from count 5.
    b_rst = 1'b1; tick(); b_rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      b_i = ~b_i;
      tick();
    end
    check("mid_b_cnt5", 32'(b_cnt), 32'h5);
    b_rst = 1'b1; a_rst = 1'b1;
    b_i = 1'b1; a_i = 4'b0110;
    #1;
    check("mid_b_O", 32'(b_o), 32'h0);
    tick();
    check("mid_b_cnt0", 32'(b_cnt), 32'h0);
    check("mid_b_O_q", 32'(b_oq), 32'h1);
    check("mid_a_cnt0", 32'(a_cnt), 32'h0);
    check("mid_a_O", 32'(a_o), 32'h9);
    b_rst = 1'b0; a_rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: run did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
